// File: rtl/branch_predict_unit_if.sv
// Fetch/execute-side bus of the branch predict unit: prediction lookup, resolution request,
// registered result and performance counters.
interface branch_predict_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  fetch_pc;
  logic             pred_taken;
  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_rs1;
  logic [XLEN-1:0]  ex_rs2;
  logic [4:0]       ex_brop;
  logic             ex_pred_taken;
  logic             flush;
  logic             res_valid;
  logic             res_taken;
  logic             res_mispredict;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mis_count;

  modport master (
    output fetch_pc, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_brop, ex_pred_taken, flush,
    input  pred_taken, res_valid, res_taken, res_mispredict, br_count, mis_count
  );

  modport slave (
    input  fetch_pc, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_brop, ex_pred_taken, flush,
    output pred_taken, res_valid, res_taken, res_mispredict, br_count, mis_count
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Execute-stage branch/jump resolver with a bimodal 2-bit BHT for fetch prediction
// and saturating branch / misprediction counters.
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  branch_predict_unit_if.slave bus
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] fidx, eidx;
  logic             is_jmp, is_cond, accept, cond, taken, mispred;
  logic [1:0]       ctr_cur, ctr_nxt;
  logic             res_valid_q, res_taken_q, res_mis_q;
  logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;

  assign fidx           = bus.fetch_pc[IDX_W+1:2];
  assign eidx           = bus.ex_pc[IDX_W+1:2];
  assign bus.pred_taken = bht[fidx][1];

  assign is_jmp  = bus.ex_brop[4];
  assign is_cond = (bus.ex_brop[4:3] == 2'b01);
  assign accept  = bus.ex_valid & ~bus.flush & (is_jmp | is_cond);

  // Reserved codes 010/011 fall through to not-taken.
  always_comb begin
    cond = 1'b0;
    case (bus.ex_brop[2:0])
      3'b000:  cond = (bus.ex_rs1 == bus.ex_rs2);
      3'b001:  cond = (bus.ex_rs1 != bus.ex_rs2);
      3'b100:  cond = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
      3'b101:  cond = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
      3'b110:  cond = (bus.ex_rs1 <  bus.ex_rs2);
      3'b111:  cond = (bus.ex_rs1 >= bus.ex_rs2);
      default: cond = 1'b0;
    endcase
  end

  assign taken   = is_jmp | cond;
  assign mispred = is_jmp | (cond != bus.ex_pred_taken);

  assign ctr_cur = bht[eidx];
  always_comb begin
    ctr_nxt = ctr_cur;
    if (cond && ctr_cur != 2'b11)       ctr_nxt = ctr_cur + 2'd1;
    else if (!cond && ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (accept && is_cond) begin
      bht[eidx] <= ctr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
      res_mis_q   <= 1'b0;
      br_cnt_q    <= '0;
      mis_cnt_q   <= '0;
    end else begin
      res_valid_q <= accept;
      res_taken_q <= accept & taken;
      res_mis_q   <= accept & mispred;
      if (accept && br_cnt_q != '1)              br_cnt_q  <= br_cnt_q + 1'b1;
      if (accept && mispred && mis_cnt_q != '1)  mis_cnt_q <= mis_cnt_q + 1'b1;
    end
  end

  assign bus.res_valid      = res_valid_q;
  assign bus.res_taken      = res_taken_q;
  assign bus.res_mispredict = res_mis_q;
  assign bus.br_count       = br_cnt_q;
  assign bus.mis_count      = mis_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit (BHT_ENTRIES=64, CNT_W=4 so counter saturation is reachable).
module tb_branch_predict_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  branch_predict_unit_if #(.XLEN(32), .CNT_W(4)) bus ();

  branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single edge, then drop ex_valid/flush.
  task automatic op(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                    input logic [4:0] brop, input logic pred, input logic fl);
    bus.ex_valid      = 1'b1;
    bus.flush         = fl;
    bus.ex_pc         = pc;
    bus.ex_rs1        = rs1;
    bus.ex_rs2        = rs2;
    bus.ex_brop       = brop;
    bus.ex_pred_taken = pred;
    tick();
    bus.ex_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic v, input logic t, input logic m,
                         input int br, input int mis);
    chk({tag, ".valid"}, 32'(bus.res_valid), 32'(v));
    chk({tag, ".taken"}, 32'(bus.res_taken), 32'(t));
    chk({tag, ".mis"},   32'(bus.res_mispredict), 32'(m));
    chk({tag, ".br"},    32'(bus.br_count), 32'(br));
    chk({tag, ".miscnt"}, 32'(bus.mis_count), 32'(mis));
  endtask

  task automatic chk_pred(input string tag, input logic [31:0] pc, input logic exp);
    bus.fetch_pc = pc;
    #1;
    chk(tag, 32'(bus.pred_taken), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    bus.fetch_pc = '0; bus.ex_valid = 1'b0; bus.flush = 1'b0; bus.ex_pc = '0;
    bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_brop = '0; bus.ex_pred_taken = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    chk_pred("rst_pred100", 32'h100, 1'b0);
    chk_res("rst", 0, 0, 0, 0, 0);

    // BLT signed: -1 < 1 taken, predicted NT -> mispredict. BHT[0] 01->10.
    op(32'h0, 32'hFFFF_FFFF, 32'h1, 5'b01100, 1'b0, 1'b0);
    chk_res("blt", 1, 1, 1, 1, 1);
    // BLTU: 0xFFFFFFFF < 1 false. BHT[2] 01->00.
    op(32'h8, 32'hFFFF_FFFF, 32'h1, 5'b01110, 1'b0, 1'b0);
    chk_res("bltu", 1, 0, 0, 2, 1);
    tick();
    chk_res("idle", 0, 0, 0, 2, 1);

    // Three taken BEQ at 0x40: 01->10->11->11.
    chk_pred("pred40_init", 32'h40, 1'b0);
    op(32'h40, 32'h5, 32'h5, 5'b01000, 1'b0, 1'b0);
    chk_res("beq1", 1, 1, 1, 3, 2);
    chk_pred("pred40_b1", 32'h40, 1'b1);
    op(32'h40, 32'h5, 32'h5, 5'b01000, 1'b0, 1'b0);
    op(32'h40, 32'h5, 32'h5, 5'b01000, 1'b0, 1'b0);
    chk_res("beq3", 1, 1, 1, 5, 4);
    chk_pred("pred40", 32'h40, 1'b1);
    chk_pred("pred140_alias", 32'h140, 1'b1);
    chk_pred("pred44", 32'h44, 1'b0);

    // Not-taken BEQ steps 11->10 (still T), then 10->01 (NT): proves saturation held at 11.
    op(32'h40, 32'h5, 32'h6, 5'b01000, 1'b1, 1'b0);
    chk_res("beq_nt1", 1, 0, 1, 6, 5);
    chk_pred("pred40_nt1", 32'h40, 1'b1);
    op(32'h40, 32'h5, 32'h6, 5'b01000, 1'b0, 1'b0);
    chk_res("beq_nt2", 1, 0, 0, 7, 5);
    chk_pred("pred40_nt2", 32'h40, 1'b0);

    // Jump: always taken and mispredicted, BHT untouched.
    op(32'h44, 32'h0, 32'h0, 5'b10000, 1'b1, 1'b0);
    chk_res("jmp", 1, 1, 1, 8, 6);
    chk_pred("pred44_jmp", 32'h44, 1'b0);

    // Flushed taken branch, non-branch op, and invalid branch: no effect.
    op(32'h44, 32'h5, 32'h5, 5'b01000, 1'b0, 1'b1);
    chk_res("flush", 0, 0, 0, 8, 6);
    chk_pred("pred44_flush", 32'h44, 1'b0);
    op(32'h44, 32'h5, 32'h5, 5'b00101, 1'b0, 1'b0);
    chk_res("nonbr", 0, 0, 0, 8, 6);
    bus.ex_pc = 32'h44; bus.ex_rs1 = 32'h5; bus.ex_rs2 = 32'h5;
    bus.ex_brop = 5'b01000; bus.ex_valid = 1'b0;
    tick();
    chk_res("novalid", 0, 0, 0, 8, 6);
    chk_pred("pred44_hold", 32'h44, 1'b0);

    // Reserved code: resolves not-taken and decrements BHT[0] 10->01.
    chk_pred("pred0_pre", 32'h0, 1'b1);
    op(32'h0, 32'h5, 32'h5, 5'b01010, 1'b0, 1'b0);
    chk_res("resv", 1, 0, 0, 9, 6);
    chk_pred("pred0_resv", 32'h0, 1'b0);

    // BGE signed -1 >= 1 false; BGEU 0xFFFFFFFF >= 1 true.
    op(32'hC0, 32'hFFFF_FFFF, 32'h1, 5'b01101, 1'b0, 1'b0);
    chk_res("bge", 1, 0, 0, 10, 6);
    op(32'hC4, 32'hFFFF_FFFF, 32'h1, 5'b01111, 1'b1, 1'b0);
    chk_res("bgeu", 1, 1, 0, 11, 6);

    // 20 mispredicting BNEs: both counters saturate at 15.
    for (int i = 0; i < 20; i++) op(32'h80, 32'h1, 32'h2, 5'b01001, 1'b0, 1'b0);
    chk_res("sat", 1, 1, 1, 15, 15);
    chk_pred("pred80_sat", 32'h80, 1'b1);

    // Reset wins over a concurrent op.
    rst = 1'b1;
    op(32'h80, 32'h1, 32'h2, 5'b01001, 1'b0, 1'b0);
    rst = 1'b0;
    chk_res("rst_mid", 0, 0, 0, 0, 0);
    chk_pred("pred80_rst", 32'h80, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
